// File: rtl/rtc_timer_if.sv
// -----------------------------------------------------------------------------
// rtc_timer_if
// Register access bus for rtc_timer: a one-cycle write strobe and a one-cycle
// read strobe with a registered read return.
//
// Signals:
//   wr_en    : write strobe, one cycle
//   wr_addr  : write select (0=mtime_lo, 1=mtime_hi, 2=cmp_lo, 3=cmp_hi)
//   wr_data  : write data
//   rd_en    : read strobe, one cycle
//   rd_addr  : read select, same map as wr_addr
//   rd_data  : read data, valid while rd_valid=1, held until the next read
//   rd_valid : one-cycle read-return pulse, one cycle after rd_en
//
// Modports: master (bus initiator), slave (rtc_timer).
// -----------------------------------------------------------------------------
interface rtc_timer_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/rtc_timer.sv
// -----------------------------------------------------------------------------
// rtc_timer
// Machine timer: a CNT_W-bit mtime counter advanced once per rising edge of the
// divided RTC clock (rtc_tick_clk, already in the clk domain), plus an optional
// mtimecmp compare register driving a level interrupt.
//
// Ports:
//   clk          : system clock, single domain
//   rst          : synchronous active-high reset
//   rtc_tick_clk : divided RTC clock, registered in the clk domain
//   rtc_en       : count enable; ticks seen while low are lost
//   bus          : rtc_timer_if.slave register access bus
//   irq          : timer interrupt, level, registered (mtime >= mtimecmp)
//
// Configuration:
//   RTC_TIMER_IRQ_EN : when defined, mtimecmp, the comparator and irq exist.
//                      When undefined, irq is tied to 0, writes to addresses
//                      2/3 are ignored and reads of addresses 2/3 return 0.
//
// Reading mtime is split: a read of mtime_lo captures the upper bits into a
// shadow, and a read of mtime_hi returns that shadow, so a lo-then-hi pair is
// coherent even if the counter carries between the two reads.
// -----------------------------------------------------------------------------
module rtc_timer #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rtc_tick_clk,
    input  logic        rtc_en,
    rtc_timer_if.slave  bus,
    output logic        irq
);

    localparam int               HI_W    = CNT_W - 32;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       A_MT_LO = 2'd0;
    localparam logic [1:0]       A_MT_HI = 2'd1;
    localparam logic [1:0]       A_CM_LO = 2'd2;
    localparam logic [1:0]       A_CM_HI = 2'd3;

    // Zero-extend an upper-half value onto the 32-bit read bus.
    function automatic logic [31:0] zext_hi(input logic [HI_W-1:0] v);
        logic [31:0] r;
        r         = 32'h0000_0000;
        r[HI_W-1:0] = v;
        return r;
    endfunction

    logic             tick_d_q;
    logic             tick_s;
    logic             wr_mt_lo_s;
    logic             wr_mt_hi_s;
    logic [CNT_W-1:0] mtime_q;
    logic [CNT_W-1:0] mtime_d;
    logic [HI_W-1:0]  shadow_q;
    logic [HI_W-1:0]  shadow_d;
    logic [31:0]      rd_data_q;
    logic [31:0]      rd_data_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic [31:0]      rd_mux_s;
    logic [31:0]      cmp_lo_rd_s;
    logic [31:0]      cmp_hi_rd_s;

    // Rising-edge detect on the already-synchronous divided clock.
    assign tick_s     = rtc_tick_clk & ~tick_d_q;
    assign wr_mt_lo_s = bus.wr_en && (bus.wr_addr == A_MT_LO);
    assign wr_mt_hi_s = bus.wr_en && (bus.wr_addr == A_MT_HI);

    // Edge detector history register; keeps tracking even while rtc_en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_d_q <= 1'b0;
        end else begin
            tick_d_q <= rtc_tick_clk;
        end
    end

    // mtime next state: a bus write wins and the same-cycle increment is dropped.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mt_lo_s) begin
            mtime_d[31:0] = bus.wr_data;
        end else if (wr_mt_hi_s) begin
            mtime_d[CNT_W-1:32] = bus.wr_data[HI_W-1:0];
        end else if (tick_s && rtc_en) begin
            mtime_d = mtime_q + CNT_ONE;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // mtime register; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q <= '0;
        end else begin
            mtime_d_unused_guard: mtime_q <= mtime_d;
        end
    end

`ifdef RTC_TIMER_IRQ_EN
    logic [CNT_W-1:0] cmp_q;
    logic [CNT_W-1:0] cmp_d;
    logic             irq_q;
    logic             irq_d;

    // mtimecmp next state from cmp_lo / cmp_hi writes.
    always_comb begin
        cmp_d = cmp_q;
        if (bus.wr_en && (bus.wr_addr == A_CM_LO)) begin
            cmp_d[31:0] = bus.wr_data;
        end else if (bus.wr_en && (bus.wr_addr == A_CM_HI)) begin
            cmp_d[CNT_W-1:32] = bus.wr_data[HI_W-1:0];
        end else begin
            cmp_d = cmp_q;
        end
    end

    // Compare on the registered (already updated) values, so irq follows a
    // change of mtime or mtimecmp by exactly one cycle.
    always_comb begin
        irq_d = 1'b0;
        if (mtime_q >= cmp_q) begin
            irq_d = 1'b1;
        end else begin
            irq_d = 1'b0;
        end
    end

    // mtimecmp and irq registers; all-ones compare keeps irq quiet after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp_lo_rd_s = cmp_q[31:0];
    assign cmp_hi_rd_s = zext_hi(cmp_q[CNT_W-1:32]);
    assign irq         = irq_q;
`else
    assign cmp_lo_rd_s = 32'h0000_0000;
    assign cmp_hi_rd_s = 32'h0000_0000;
    assign irq         = 1'b0;
`endif

    // Read select on the current (pre-write) register values.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (bus.rd_addr)
            A_MT_LO: rd_mux_s = mtime_q[31:0];
            A_MT_HI: rd_mux_s = zext_hi(shadow_q);
            A_CM_LO: rd_mux_s = cmp_lo_rd_s;
            A_CM_HI: rd_mux_s = cmp_hi_rd_s;
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Read return next state; a mtime_lo read also snapshots the upper bits.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        shadow_d   = shadow_q;
        if (bus.rd_en) begin
            rd_data_d = rd_mux_s;
            if (bus.rd_addr == A_MT_LO) begin
                shadow_d = mtime_q[CNT_W-1:32];
            end else begin
                shadow_d = shadow_q;
            end
        end else begin
            rd_data_d = rd_data_q;
            shadow_d  = shadow_q;
        end
    end

    // Read return registers; reset drops any read pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= 32'h0000_0000;
            rd_valid_q <= 1'b0;
            shadow_q   <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_rtc_timer.sv
module tb_rtc_timer;

`ifdef RTC_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic tclk;
    logic en;
    logic irq;

    rtc_timer_if bus ();

    rtc_timer #(.CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .rtc_tick_clk (tclk),
        .rtc_en       (en),
        .bus          (bus),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state (what the spec says the block holds).
    bit [63:0] m_mtime;
    bit [63:0] m_cmp;
    bit [31:0] m_shadow;
    bit [31:0] m_rdd;
    bit        m_rv;
    bit        m_irq;
    bit        m_prev_tclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model by one clk edge using the inputs now driven.
    task automatic model_step();
        bit        tick;
        bit [63:0] n_mtime;
        bit [63:0] n_cmp;
        bit        n_irq;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_rdd = 32'd0;
            m_rv = 1'b0; m_irq = 1'b0; m_prev_tclk = 1'b0;
        end else begin
            tick  = tclk && !m_prev_tclk;
            n_irq = IRQ_EN && (m_mtime >= m_cmp);
            m_rv  = bus.rd_en;
            if (bus.rd_en) begin
                case (bus.rd_addr)
                    2'd0: m_rdd = m_mtime[31:0];
                    2'd1: m_rdd = m_shadow;
                    2'd2: m_rdd = IRQ_EN ? m_cmp[31:0] : 32'd0;
                    default: m_rdd = IRQ_EN ? m_cmp[63:32] : 32'd0;
                endcase
                if (bus.rd_addr == 2'd0) m_shadow = m_mtime[63:32];
            end
            n_mtime = m_mtime;
            n_cmp   = m_cmp;
            if (bus.wr_en && bus.wr_addr == 2'd0)      n_mtime = {m_mtime[63:32], bus.wr_data};
            else if (bus.wr_en && bus.wr_addr == 2'd1) n_mtime = {bus.wr_data, m_mtime[31:0]};
            else if (tick && en)                       n_mtime = m_mtime + 64'd1;
            if (IRQ_EN && bus.wr_en && bus.wr_addr == 2'd2) n_cmp = {m_cmp[63:32], bus.wr_data};
            if (IRQ_EN && bus.wr_en && bus.wr_addr == 2'd3) n_cmp = {bus.wr_data, m_cmp[31:0]};
            m_mtime = n_mtime;
            m_cmp   = n_cmp;
            m_irq   = n_irq;
            m_prev_tclk = tclk;
        end
    endtask

    // One clock cycle: model update, edge, then compare all outputs to the model.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("model_rd_valid", {63'd0, bus.rd_valid}, {63'd0, m_rv});
        chk("model_rd_data", {32'd0, bus.rd_data}, {32'd0, m_rdd});
        chk("model_irq", {63'd0, irq}, {63'd0, m_irq});
        chk("model_mtime", dut.mtime_q, m_mtime);
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 32'd0;
        bus.rd_en = 1'b0; bus.rd_addr = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1; tclk = 1'b0; en = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_write(input bit [1:0] a, input bit [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        cycle();
        idle();
    endtask

    task automatic do_read(input string name, input bit [1:0] a, input bit [31:0] exp);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        cycle();
        chk({name, "_valid"}, {63'd0, bus.rd_valid}, 64'd1);
        chk(name, {32'd0, bus.rd_data}, {32'd0, exp});
        idle();
    endtask

    // n periods of the divide-by-6 RTC clock: 3 cycles high, 3 low.
    task automatic period(input int n);
        for (int p = 0; p < n; p++) begin
            tclk = 1'b1; cycle(); cycle(); cycle();
            tclk = 1'b0; cycle(); cycle(); cycle();
        end
    endtask

    typedef struct {
        bit        wr_en;
        bit [1:0]  wa;
        bit [31:0] wd;
        bit        rd_en;
        bit [1:0]  ra;
        bit        ev;
        bit [31:0] ed;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 2'd0, 32'h1234_5678, 1'b1, 2'd0, 1'b1, 32'h0000_0000};
        vt[1] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd0, 1'b1, 32'h1234_5678};
        vt[2] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 1'b1, 2'd1, 1'b1, 32'h0000_0000};
        vt[3] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd1, 1'b1, 32'h0000_0000};
        vt[4] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd0, 1'b1, 32'h1234_5678};
        vt[5] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd1, 1'b1, 32'hDEAD_BEEF};
        vt[6] = '{1'b0, 2'd0, 32'h0,         1'b0, 2'd0, 1'b0, 32'hDEAD_BEEF};
        vt[7] = '{1'b1, 2'd2, 32'h0000_AAAA, 1'b1, 2'd2, 1'b1, IRQ_EN ? 32'hFFFF_FFFF : 32'h0};
        vt[8] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd2, 1'b1, IRQ_EN ? 32'h0000_AAAA : 32'h0};
        vt[9] = '{1'b0, 2'd0, 32'h0,         1'b1, 2'd3, 1'b1, IRQ_EN ? 32'hFFFF_FFFF : 32'h0};

        m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_rdd = 32'd0;
        m_rv = 1'b0; m_irq = 1'b0; m_prev_tclk = 1'b0;
        rst = 1'b1; tclk = 1'b0; en = 1'b0;
        idle();

        // Reset state
        do_reset();
        chk("rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        chk("rst_rd_data", {32'd0, bus.rd_data}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_mtime", dut.mtime_q, 64'd0);

        // Register map table: read-before-write, hi shadow, held data, cmp addresses
        for (int i = 0; i < 10; i++) begin
            bus.wr_en = vt[i].wr_en; bus.wr_addr = vt[i].wa; bus.wr_data = vt[i].wd;
            bus.rd_en = vt[i].rd_en; bus.rd_addr = vt[i].ra;
            cycle();
            chk($sformatf("vec%0d_valid", i), {63'd0, bus.rd_valid}, {63'd0, vt[i].ev});
            chk($sformatf("vec%0d_data", i), {32'd0, bus.rd_data}, {32'd0, vt[i].ed});
        end
        idle();

        // Ten RTC periods counted, then a latency-1 read of mtime_lo
        do_reset();
        en = 1'b1;
        period(10);
        chk("cnt10_idle_valid", {63'd0, bus.rd_valid}, 64'd0);
        do_read("cnt10_lo", 2'd0, 32'd10);

        // Wrap from all-ones-minus-one through zero
        en = 1'b0;
        do_write(2'd0, 32'hFFFF_FFFE);
        do_write(2'd1, 32'hFFFF_FFFF);
        en = 1'b1;
        period(3);
        en = 1'b0;
        do_read("wrap_lo", 2'd0, 32'd1);
        do_read("wrap_hi", 2'd1, 32'd0);

        // Hi shadow across a carry
        do_reset();
        do_write(2'd0, 32'hFFFF_FFFF);
        do_write(2'd1, 32'h0);
        do_read("shadow_lo1", 2'd0, 32'hFFFF_FFFF);
        en = 1'b1;
        period(1);
        en = 1'b0;
        do_read("shadow_hi1", 2'd1, 32'd0);
        do_read("shadow_lo2", 2'd0, 32'd0);
        do_read("shadow_hi2", 2'd1, 32'd1);

        // Write beats a same-cycle tick, then reset mid-count dominating everything
        do_reset();
        en = 1'b1;
        tclk = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 32'h55;
        cycle();
        idle();
        cycle(); cycle();
        tclk = 1'b0; cycle(); cycle(); cycle();
        do_read("wr_vs_tick", 2'd0, 32'h55);
        period(4);
        do_read("count_on", 2'd0, 32'h59);
        rst = 1'b1; tclk = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 32'h77;
        bus.rd_en = 1'b1; bus.rd_addr = 2'd0;
        cycle();
        chk("midrst_valid", {63'd0, bus.rd_valid}, 64'd0);
        chk("midrst_data", {32'd0, bus.rd_data}, 64'd0);
        chk("midrst_irq", {63'd0, irq}, 64'd0);
        chk("midrst_mtime", dut.mtime_q, 64'd0);
        rst = 1'b0;
        idle();
        cycle();
        chk("postrst_valid", {63'd0, bus.rd_valid}, 64'd0);

        // rtc_en=0 loses a tick rather than deferring it
        do_reset();
        en = 1'b1;
        period(2);
        en = 1'b0;
        tclk = 1'b1; cycle();
        en = 1'b1; cycle(); cycle();
        tclk = 1'b0; cycle(); cycle(); cycle();
        do_read("lost_tick", 2'd0, 32'd2);
        period(1);
        do_read("after_lost", 2'd0, 32'd3);

`ifdef RTC_TIMER_IRQ_EN
        // irq rises one cycle after mtime reaches cmp, falls one cycle after cmp is raised
        do_reset();
        do_write(2'd3, 32'd0);
        do_write(2'd2, 32'd5);
        en = 1'b1;
        period(4);
        chk("irq_below", {63'd0, irq}, 64'd0);
        tclk = 1'b1;
        cycle();
        chk("irq_at5_mtime", dut.mtime_q, 64'd5);
        chk("irq_at5_same", {63'd0, irq}, 64'd0);
        cycle();
        chk("irq_rise", {63'd0, irq}, 64'd1);
        en = 1'b0; tclk = 1'b0;
        do_write(2'd2, 32'd100);
        chk("irq_hold", {63'd0, irq}, 64'd1);
        cycle();
        chk("irq_fall", {63'd0, irq}, 64'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) tclk = ~tclk;
            bus.wr_en   = ($urandom_range(0, 4) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 15));
            bus.rd_en   = ($urandom_range(0, 2) == 0);
            bus.rd_addr = 2'($urandom_range(0, 3));
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
